// File: rtl/painterengine_gpu_dma_writer_mc.sv
// Multi-channel AXI4 write DMA: streams a selected channel's beats to memory in 4 KB-safe bursts.
// One burst in flight at a time; each AXI handshake has an idle-cycle watchdog.
module painterengine_gpu_dma_writer_mc #(
    parameter int PARAM_CHANNELS   = 4,
    parameter int PARAM_DATA_WIDTH = 32,
    parameter int PARAM_MAX_BURST  = 256,
    parameter int PARAM_TIMEOUT    = 256
) (
    input  logic                                       i_wire_clock,
    input  logic                                       i_wire_reset,
    input  logic                                       i_wire_start,
    input  logic [PARAM_CHANNELS-1:0]                  i_wire_router,
    input  logic [32*PARAM_CHANNELS-1:0]               i_wire_address,
    input  logic [32*PARAM_CHANNELS-1:0]               i_wire_length,
    input  logic [PARAM_DATA_WIDTH*PARAM_CHANNELS-1:0] i_wire_data,
    input  logic [PARAM_CHANNELS-1:0]                  i_wire_data_valid,
    output logic [PARAM_CHANNELS-1:0]                  o_wire_data_next,
    output logic                                       o_wire_busy,
    output logic                                       o_wire_done,
    output logic                                       o_wire_error,
    output logic [2:0]                                 o_wire_error_type,
    output logic                                       o_wire_M_AXI_AWID,
    output logic [31:0]                                o_wire_M_AXI_AWADDR,
    output logic [7:0]                                 o_wire_M_AXI_AWLEN,
    output logic [2:0]                                 o_wire_M_AXI_AWSIZE,
    output logic [1:0]                                 o_wire_M_AXI_AWBURST,
    output logic                                       o_wire_M_AXI_AWLOCK,
    output logic [3:0]                                 o_wire_M_AXI_AWCACHE,
    output logic [2:0]                                 o_wire_M_AXI_AWPROT,
    output logic [3:0]                                 o_wire_M_AXI_AWQOS,
    output logic                                       o_wire_M_AXI_AWVALID,
    input  logic                                       i_wire_M_AXI_AWREADY,
    output logic [PARAM_DATA_WIDTH-1:0]                o_wire_M_AXI_WDATA,
    output logic [PARAM_DATA_WIDTH/8-1:0]              o_wire_M_AXI_WSTRB,
    output logic                                       o_wire_M_AXI_WLAST,
    output logic                                       o_wire_M_AXI_WVALID,
    input  logic                                       i_wire_M_AXI_WREADY,
    input  logic [1:0]                                 i_wire_M_AXI_BRESP,
    input  logic                                       i_wire_M_AXI_BVALID,
    output logic                                       o_wire_M_AXI_BREADY
);

    localparam int SZ = $clog2(PARAM_DATA_WIDTH / 8);
    localparam int TW = $clog2(PARAM_TIMEOUT + 1);
    localparam int SW = (PARAM_CHANNELS > 1) ? $clog2(PARAM_CHANNELS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_CALC, S_ADDR, S_DATA, S_RESP, S_DONE, S_ERROR
    } state_t;

    state_t                      state_q, state_d;
    logic [PARAM_CHANNELS-1:0]   router_q, router_d;
    logic [SW-1:0]               sel_q, sel_d, start_sel;
    logic [31:0]                 addr_q, addr_d, len_q, len_d, offset_q, offset_d;
    logic [31:0]                 cur_addr_q, cur_addr_d;
    logic [8:0]                  burst_q, burst_d, beat_q, beat_d;
    logic [TW-1:0]               tmo_q, tmo_d;
    logic [2:0]                  err_q, err_d;

    logic [31:0]                 calc_addr, to4k, remain;
    logic [8:0]                  calc_burst;
    logic [PARAM_DATA_WIDTH-1:0] sel_data;
    logic                        sel_valid, hs_aw, hs_w, hs_b, timeout, last_beat;
    logic                        unused_bresp0;

    assign unused_bresp0 = i_wire_M_AXI_BRESP[0];

    always_comb begin
        start_sel = '0;
        for (int i = PARAM_CHANNELS - 1; i >= 0; i--) begin
            if (i_wire_router[i]) start_sel = SW'(i);
        end
    end

    assign sel_data  = i_wire_data[sel_q*PARAM_DATA_WIDTH +: PARAM_DATA_WIDTH];
    assign sel_valid = i_wire_data_valid[sel_q];
    assign hs_aw     = (state_q == S_ADDR) && i_wire_M_AXI_AWREADY;
    assign hs_w      = (state_q == S_DATA) && sel_valid && i_wire_M_AXI_WREADY;
    assign hs_b      = (state_q == S_RESP) && i_wire_M_AXI_BVALID;
    assign timeout   = (tmo_q == TW'(PARAM_TIMEOUT - 1));
    assign last_beat = (beat_q == burst_q - 9'd1);

    // Burst never exceeds the cap, the remaining job, or the next 4 KB page boundary.
    always_comb begin
        calc_addr  = addr_q + (offset_q << SZ);
        to4k       = (32'h1000 - {20'd0, calc_addr[11:0]}) >> SZ;
        remain     = len_q - offset_q;
        calc_burst = 9'(PARAM_MAX_BURST);
        if (remain < 32'(calc_burst)) calc_burst = remain[8:0];
        if (to4k < 32'(calc_burst))   calc_burst = to4k[8:0];
    end

    always_comb begin
        state_d    = state_q;
        router_d   = router_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        len_d      = len_q;
        offset_d   = offset_q;
        cur_addr_d = cur_addr_q;
        burst_d    = burst_q;
        beat_d     = beat_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_wire_start) begin
                    state_d  = S_CHECK;
                    router_d = i_wire_router;
                    sel_d    = start_sel;
                    addr_d   = i_wire_address[start_sel*32 +: 32];
                    len_d    = i_wire_length[start_sel*32 +: 32];
                    offset_d = '0;
                    err_d    = 3'd0;
                end
            end
            S_CHECK: begin
                if (!$onehot(router_q)) begin
                    state_d = S_ERROR; err_d = 3'd1;
                end else if (addr_q[SZ-1:0] != '0) begin
                    state_d = S_ERROR; err_d = 3'd2;
                end else if (len_q == 32'd0) begin
                    state_d = S_ERROR; err_d = 3'd3;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                cur_addr_d = calc_addr;
                burst_d    = calc_burst;
                beat_d     = '0;
                state_d    = S_ADDR;
            end
            S_ADDR: begin
                if (hs_aw)        state_d = S_DATA;
                else if (timeout) begin state_d = S_ERROR; err_d = 3'd4; end
            end
            S_DATA: begin
                if (hs_w) begin
                    if (last_beat) begin
                        state_d  = S_RESP;
                        offset_d = offset_q + 32'(burst_q);
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end else if (timeout) begin
                    state_d = S_ERROR; err_d = 3'd5;
                end
            end
            S_RESP: begin
                if (hs_b) begin
                    if (i_wire_M_AXI_BRESP[1])  begin state_d = S_ERROR; err_d = 3'd6; end
                    else if (offset_q == len_q) state_d = S_DONE;
                    else                        state_d = S_CALC;
                end else if (timeout) begin
                    state_d = S_ERROR; err_d = 3'd7;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Watchdog only runs while waiting on the AXI side.
        if (state_d != state_q || hs_aw || hs_w || hs_b)
            tmo_d = '0;
        else if (state_q == S_ADDR || state_q == S_DATA || state_q == S_RESP)
            tmo_d = tmo_q + TW'(1);
        else
            tmo_d = '0;
    end

    always_comb begin
        o_wire_busy          = (state_q == S_CHECK) || (state_q == S_CALC) || (state_q == S_ADDR) ||
                               (state_q == S_DATA)  || (state_q == S_RESP);
        o_wire_done          = (state_q == S_DONE);
        o_wire_error         = (state_q == S_ERROR);
        o_wire_error_type    = err_q;
        o_wire_M_AXI_AWVALID = (state_q == S_ADDR);
        o_wire_M_AXI_AWADDR  = (state_q == S_ADDR) ? cur_addr_q : 32'd0;
        o_wire_M_AXI_AWLEN   = (state_q == S_ADDR) ? 8'(burst_q - 9'd1) : 8'd0;
        o_wire_M_AXI_WVALID  = (state_q == S_DATA) && sel_valid;
        o_wire_M_AXI_WDATA   = (state_q == S_DATA) ? sel_data : '0;
        o_wire_M_AXI_WLAST   = (state_q == S_DATA) && last_beat;
        o_wire_M_AXI_BREADY  = (state_q == S_RESP);
        o_wire_data_next     = '0;
        o_wire_data_next[sel_q] = hs_w;
    end

    assign o_wire_M_AXI_AWID    = 1'b0;
    assign o_wire_M_AXI_AWSIZE  = 3'(SZ);
    assign o_wire_M_AXI_AWBURST = 2'b01;
    assign o_wire_M_AXI_AWLOCK  = 1'b0;
    assign o_wire_M_AXI_AWCACHE = 4'b0010;
    assign o_wire_M_AXI_AWPROT  = 3'b000;
    assign o_wire_M_AXI_AWQOS   = 4'b0000;
    assign o_wire_M_AXI_WSTRB   = '1;

    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) begin
            state_q    <= S_IDLE;
            router_q   <= '0;
            sel_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            offset_q   <= '0;
            cur_addr_q <= '0;
            burst_q    <= '0;
            beat_q     <= '0;
            tmo_q      <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            router_q   <= router_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            offset_q   <= offset_d;
            cur_addr_q <= cur_addr_d;
            burst_q    <= burst_d;
            beat_q     <= beat_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_painterengine_gpu_dma_writer_mc.sv
// Bench for painterengine_gpu_dma_writer_mc: job table, random jobs, reset-mid-burst sequence.
module tb_painterengine_gpu_dma_writer_mc;
    localparam int CH = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [CH-1:0]   router = '0;
    logic [32*CH-1:0] address = '0, length = '0;
    logic [DW*CH-1:0] data;
    logic [CH-1:0]   dv = '0;
    logic [CH-1:0]   data_next;
    logic            busy, done, error;
    logic [2:0]      error_type;
    logic            awid, awlock, awvalid, wlast, wvalid, bready;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize, awprot;
    logic [1:0]      awburst;
    logic [3:0]      awcache, awqos;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [1:0]      bresp = 2'b00;

    logic [23:0] beat_cnt [CH];
    for (genvar g = 0; g < CH; g++) begin : g_data
        assign data[g*DW +: DW] = {8'(g), beat_cnt[g]};
    end

    always #5 clk = ~clk;

    painterengine_gpu_dma_writer_mc dut (
        .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_start(start), .i_wire_router(router),
        .i_wire_address(address), .i_wire_length(length), .i_wire_data(data),
        .i_wire_data_valid(dv), .o_wire_data_next(data_next), .o_wire_busy(busy),
        .o_wire_done(done), .o_wire_error(error), .o_wire_error_type(error_type),
        .o_wire_M_AXI_AWID(awid), .o_wire_M_AXI_AWADDR(awaddr), .o_wire_M_AXI_AWLEN(awlen),
        .o_wire_M_AXI_AWSIZE(awsize), .o_wire_M_AXI_AWBURST(awburst), .o_wire_M_AXI_AWLOCK(awlock),
        .o_wire_M_AXI_AWCACHE(awcache), .o_wire_M_AXI_AWPROT(awprot), .o_wire_M_AXI_AWQOS(awqos),
        .o_wire_M_AXI_AWVALID(awvalid), .i_wire_M_AXI_AWREADY(awready),
        .o_wire_M_AXI_WDATA(wdata), .o_wire_M_AXI_WSTRB(wstrb), .o_wire_M_AXI_WLAST(wlast),
        .o_wire_M_AXI_WVALID(wvalid), .i_wire_M_AXI_WREADY(wready),
        .i_wire_M_AXI_BRESP(bresp), .i_wire_M_AXI_BVALID(bvalid), .o_wire_M_AXI_BREADY(bready)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] a;
        int          n;
    } burst_t;
    burst_t exp_q[$];

    // Reference burst split: cap 256 beats, never cross a 4 KB page (4-byte beats).
    task automatic model_bursts(input logic [31:0] addr, input int len);
        int off;
        int n;
        int room;
        logic [31:0] cur;
        burst_t b;
        exp_q.delete();
        off = 0;
        while (off < len) begin
            cur  = addr + 32'(off * 4);
            room = (4096 - int'(cur % 4096)) / 4;
            n    = len - off;
            if (n > 256)  n = 256;
            if (n > room) n = room;
            b.a = cur;
            b.n = n;
            exp_q.push_back(b);
            off += n;
        end
    endtask

    task automatic launch(input logic [3:0] rt, input logic [31:0] addr, input logic [31:0] len, input int sel);
        for (int i = 0; i < CH; i++) begin
            address[i*32 +: 32] = $urandom;
            length[i*32 +: 32]  = 32'($urandom_range(1, 50));
        end
        address[sel*32 +: 32] = addr;
        length[sel*32 +: 32]  = len;
        @(posedge clk); #1;
        router = rt;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // mode: 0 random handshakes, 1 always ready, 2 selected channel never valid, 3 error BRESP
    task automatic run_job(input logic [3:0] rt, input logic [31:0] addr, input logic [31:0] len,
                           input int mode, input logic [2:0] exp_err, input string tag);
        int sel;
        bit found;
        bit finished;
        bit pending_b;
        int aw_seen;
        int beats_total;
        int in_burst;
        int cur_n;
        int bound;
        burst_t e;
        logic [CH-1:0] exp_next;

        sel = 0;
        found = 0;
        for (int i = 0; i < CH; i++) begin
            if (rt[i] && !found) begin sel = i; found = 1; end
        end
        exp_q.delete();
        if (exp_err == 3'd0 || exp_err > 3'd3) model_bursts(addr, int'(len));
        launch(rt, addr, len, sel);
        @(negedge clk);
        chk({tag, " busy_after_start"}, busy, 1);
        chk({tag, " type_cleared"}, error_type, 0);

        finished = 0; pending_b = 0; aw_seen = 0; beats_total = 0; in_burst = 0; cur_n = 0;
        bound = 2000 + int'(len) * 8;
        for (int cyc = 0; cyc < bound && !finished; cyc++) begin
            @(posedge clk); #1;
            start   = (mode == 0 && cyc == 3);
            awready = (mode == 1) || ($urandom_range(0, 3) != 0);
            wready  = (mode == 1) || ($urandom_range(0, 3) != 0);
            dv      = (mode == 1) ? '1 : CH'($urandom);
            if (mode == 2) dv[sel] = 1'b0;
            bvalid  = pending_b && ((mode == 1) || ($urandom_range(0, 2) != 0));
            bresp   = (mode == 3) ? 2'b10 : 2'($urandom_range(0, 1));
            @(negedge clk);
            if (done || error) begin
                finished = 1;
            end else begin
                if (awvalid && pending_b) chk({tag, " aw_while_b_pending"}, 1, 0);
                if (awvalid && awready) begin
                    aw_seen++;
                    if (exp_q.size() == 0) chk({tag, " aw_unexpected"}, awaddr, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk({tag, " awaddr"}, awaddr, e.a);
                        chk({tag, " awlen"}, awlen, 64'(e.n - 1));
                        cur_n = e.n;
                        in_burst = 0;
                    end
                end
                exp_next = '0;
                if (wvalid && wready) exp_next[sel] = 1'b1;
                chk({tag, " data_next"}, data_next, exp_next);
                if (wvalid) begin
                    chk({tag, " wvalid_src"}, dv[sel], 1);
                    chk({tag, " wdata"}, wdata, {8'(sel), beat_cnt[sel]});
                    chk({tag, " wlast"}, wlast, (in_burst == cur_n - 1));
                    if (wready) begin
                        beat_cnt[sel] = beat_cnt[sel] + 24'd1;
                        beats_total++;
                        in_burst++;
                        if (wlast) pending_b = 1;
                    end
                end
                if (bvalid && bready) pending_b = 0;
            end
        end
        start = 1'b0;
        chk({tag, " job_finished_in_budget"}, finished, 1);
        chk({tag, " done"}, done, (exp_err == 0));
        chk({tag, " error"}, error, (exp_err != 0));
        chk({tag, " error_type"}, error_type, exp_err);
        if (exp_err == 0) begin
            chk({tag, " beats_total"}, beats_total, len);
            chk({tag, " bursts_left"}, exp_q.size(), 0);
        end
        if (exp_err >= 3'd1 && exp_err <= 3'd3) chk({tag, " no_aw"}, aw_seen, 0);
        @(negedge clk);
        chk({tag, " status_held"}, {busy, done, error}, {1'b0, exp_err == 0, exp_err != 0});
    endtask

    typedef struct {
        logic [3:0]  rt;
        logic [31:0] addr;
        logic [31:0] len;
        int          mode;
        logic [2:0]  err;
    } job_t;
    job_t jobs[11];

    initial begin
        bit saw_w;
        jobs[0]  = '{4'b0010, 32'h1000, 32'd300, 1, 3'd0};
        jobs[1]  = '{4'b0001, 32'h0FF0, 32'd16,  0, 3'd0};
        jobs[2]  = '{4'b0011, 32'h1000, 32'd10,  0, 3'd1};
        jobs[3]  = '{4'b0000, 32'h1000, 32'd10,  0, 3'd1};
        jobs[4]  = '{4'b0100, 32'h1002, 32'd10,  0, 3'd2};
        jobs[5]  = '{4'b1000, 32'h1000, 32'd0,   0, 3'd3};
        jobs[6]  = '{4'b0011, 32'h1002, 32'd0,   0, 3'd1};
        jobs[7]  = '{4'b0100, 32'h1001, 32'd0,   0, 3'd2};
        jobs[8]  = '{4'b0010, 32'h2000, 32'd8,   2, 3'd5};
        jobs[9]  = '{4'b1000, 32'h3000, 32'd4,   3, 3'd6};
        jobs[10] = '{4'b0001, 32'h0FFC, 32'd513, 0, 3'd0};
        for (int i = 0; i < CH; i++) beat_cnt[i] = 24'd0;

        #2 rst = 1'b1;
        #1;
        chk("reset busy/done/error", {busy, done, error}, 3'b000);
        chk("reset error_type", error_type, 0);
        chk("reset awvalid/wvalid/bready", {awvalid, wvalid, bready}, 3'b000);
        chk("reset data_next", data_next, 0);
        chk("fixed awsize", awsize, 2);
        chk("fixed awburst", awburst, 1);
        chk("fixed awcache", awcache, 4'b0010);
        chk("fixed id/lock/prot/qos", {awid, awlock, awprot, awqos}, 0);
        chk("fixed wstrb", wstrb, 4'hF);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        for (int j = 0; j < 11; j++)
            run_job(jobs[j].rt, jobs[j].addr, jobs[j].len, jobs[j].mode, jobs[j].err,
                    $sformatf("job%0d", j));

        for (int r = 0; r < 8; r++) begin
            logic [31:0] a;
            a = 32'h1000 * 32'($urandom_range(1, 6)) - 32'(4 * $urandom_range(0, 60));
            run_job(4'b0001 << $urandom_range(0, 3), a, 32'($urandom_range(1, 150)), 0, 3'd0,
                    $sformatf("rnd%0d", r));
        end

        // Reset in the middle of a data burst, with a beat on the bus.
        launch(4'b0100, 32'h0200, 32'd40, 2);
        saw_w = 0;
        for (int c = 0; c < 50 && !saw_w; c++) begin
            @(posedge clk); #1;
            awready = 1'b1; wready = 1'b1; dv = '1; bvalid = 1'b0;
            @(negedge clk);
            if (wvalid) saw_w = 1;
        end
        chk("rst_mid wvalid_seen", saw_w, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid wvalid", wvalid, 0);
        chk("rst_mid busy", busy, 0);
        chk("rst_mid awvalid/bready/next", {awvalid, bready, data_next}, 0);
        @(posedge clk); #1;
        chk("rst_mid held idle", {busy, done, error, wvalid}, 0);
        rst = 1'b0;
        run_job(4'b0100, 32'h0200, 32'd40, 0, 3'd0, "post_reset");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
